// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, command-pulse bundle and timing defaults for the clock front panel.
package clock_pkg;

    localparam int STATE_W          = 3;
    localparam int DEB_MS_DEF       = 20;
    localparam int TIMEOUT_S_DEF    = 30;
    localparam int REP_DELAY_MS_DEF = 500;
    localparam int REP_RATE_MS_DEF  = 100;

    typedef enum logic [STATE_W-1:0] {
        NORMAL    = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_SEC   = 3'd3,
        STOPWATCH = 3'd4,
        ALM_MIN   = 3'd5,
        ALM_HOUR  = 3'd6
    } mode_e;

    typedef struct packed {
        logic inc_hour;
        logic inc_min;
        logic sec_zero;
        logic inc_ahour;
        logic inc_amin;
        logic sw_clear;
    } pulse_t;

    function automatic logic is_edit(input logic [STATE_W-1:0] s);
        return s inside {SET_HOUR, SET_MIN, SET_SEC, ALM_MIN, ALM_HOUR};
    endfunction

    function automatic logic is_repeatable(input logic [STATE_W-1:0] s);
        return s inside {SET_HOUR, SET_MIN, ALM_MIN, ALM_HOUR};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus tick-counted debounce; press pulses on the debounced rising edge.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEB_MS = DEB_MS_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_MS + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn};
        cnt_d   = cnt_q;
        level_d = level_q;
        // any cycle where the input agrees with the level restarts the stability window
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            level_d = (cnt_q == CW'(DEB_MS - 1)) ? sync_q[1] : level_q;
            cnt_d   = (cnt_q == CW'(DEB_MS - 1)) ? '0 : cnt_q + CW'(1);
        end
        press_d = level_d && !level_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: three-button mode FSM issuing clock/alarm/stopwatch commands with edit timeout.
// Define AUTO_REPEAT_EN to auto-repeat a held inc button in the settable states.
module mode_sequencer
    import clock_pkg::*;
#(
    parameter int DEB_MS       = DEB_MS_DEF,
    parameter int TIMEOUT_S    = TIMEOUT_S_DEF,
    parameter int REP_DELAY_MS = REP_DELAY_MS_DEF,
    parameter int REP_RATE_MS  = REP_RATE_MS_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick_1khz,
    input  logic               tick_1hz,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_zero,
    output logic [STATE_W-1:0] state,
    output logic               inc_hour,
    output logic               inc_min,
    output logic               sec_zero,
    output logic               inc_ahour,
    output logic               inc_amin,
    output logic               sw_clear,
    output logic               sw_run,
    output logic               alarm_on,
    output logic               edit_active
);

    localparam int TW = $clog2(TIMEOUT_S + 1);

    logic               mode_p, inc_p, zero_p, inc_lvl, rep;
    logic               unused_mode_lvl, unused_zero_lvl;
    logic               m, z, i, to_hit;
    logic [STATE_W-1:0] state_q, state_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    pulse_t             pulse_q, pulse_d;
    logic               sw_run_q, sw_run_d, alarm_on_q, alarm_on_d;

    btn_debounce #(.DEB_MS(DEB_MS)) u_mode (
        .clk(clk), .clr(clr), .tick(tick_1khz), .btn(btn_mode), .level(unused_mode_lvl), .press(mode_p)
    );
    btn_debounce #(.DEB_MS(DEB_MS)) u_inc (
        .clk(clk), .clr(clr), .tick(tick_1khz), .btn(btn_inc), .level(inc_lvl), .press(inc_p)
    );
    btn_debounce #(.DEB_MS(DEB_MS)) u_zero (
        .clk(clk), .clr(clr), .tick(tick_1khz), .btn(btn_zero), .level(unused_zero_lvl), .press(zero_p)
    );

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REP_DELAY_MS + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    // after the first repeat the counter restarts part-way so later repeats come every REP_RATE_MS
    always_comb begin
        rep       = 1'b0;
        rep_cnt_d = rep_cnt_q;
        if (!(inc_lvl && is_repeatable(state_q))) begin
            rep_cnt_d = '0;
        end else if (tick_1khz) begin
            rep       = rep_cnt_q == RW'(REP_DELAY_MS - 1);
            rep_cnt_d = rep ? RW'(REP_DELAY_MS - REP_RATE_MS) : rep_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`else
    logic unused_rep;
    assign unused_rep = ^{inc_lvl, REP_DELAY_MS, REP_RATE_MS};
    assign rep        = 1'b0;
`endif

    always_comb begin
        m       = mode_p;
        z       = zero_p && !mode_p && state_q == STOPWATCH;
        i       = (inc_p || rep) && !mode_p && !z;
        to_hit  = is_edit(state_q) && to_cnt_q == TW'(TIMEOUT_S);
        state_d = (state_q > ALM_HOUR)    ? NORMAL :
                  (m && state_q == ALM_HOUR) ? NORMAL :
                  m                       ? state_q + STATE_W'(1) :
                  to_hit                  ? NORMAL : state_q;
        pulse_d           = '0;
        pulse_d.inc_hour  = i && state_q == SET_HOUR;
        pulse_d.inc_min   = i && state_q == SET_MIN;
        pulse_d.sec_zero  = i && state_q == SET_SEC;
        pulse_d.inc_ahour = i && state_q == ALM_HOUR;
        pulse_d.inc_amin  = i && state_q == ALM_MIN;
        pulse_d.sw_clear  = z;
        sw_run_d   = z ? 1'b0 : (i && state_q == STOPWATCH) ? !sw_run_q : sw_run_q;
        alarm_on_d = (i && state_q == NORMAL) ? !alarm_on_q : alarm_on_q;
        to_cnt_d   = (mode_p || inc_p || zero_p || rep || state_d != state_q) ? '0 :
                     (is_edit(state_q) && tick_1hz) ? to_cnt_q + TW'(1) : to_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= NORMAL;
            to_cnt_q   <= '0;
            pulse_q    <= '0;
            sw_run_q   <= 1'b0;
            alarm_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            pulse_q    <= pulse_d;
            sw_run_q   <= sw_run_d;
            alarm_on_q <= alarm_on_d;
        end
    end

    assign state       = state_q;
    assign inc_hour    = pulse_q.inc_hour;
    assign inc_min     = pulse_q.inc_min;
    assign sec_zero    = pulse_q.sec_zero;
    assign inc_ahour   = pulse_q.inc_ahour;
    assign inc_amin    = pulse_q.inc_amin;
    assign sw_clear    = pulse_q.sw_clear;
    assign sw_run      = sw_run_q;
    assign alarm_on    = alarm_on_q;
    assign edit_active = is_edit(state_q);

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter DEB_MS, default 20, meaning debounce stability time in tick_1khz periods.
REQ-002 SHALL have parameter TIMEOUT_S, default 30, meaning idle seconds before an edit state returns to NORMAL.
REQ-003 SHALL have parameter REP_DELAY_MS, default 500, meaning inc hold time before auto-repeat starts.
REQ-004 SHALL have parameter REP_RATE_MS, default 100, meaning auto-repeat pulse period.
REQ-005 SHALL have port clk, input, 1 bit: sole clock.
REQ-006 SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port tick_1khz, input, 1 bit: one-clk enable pulse every 1 ms.
REQ-008 SHALL have port tick_1hz, input, 1 bit: one-clk enable pulse every 1 s.
REQ-009 SHALL have ports btn_mode, btn_inc, btn_zero, input, 1 bit each: raw asynchronous buttons, high = pressed.
REQ-010 SHALL have port state, output, 3 bits: current mode.
REQ-011 SHALL have ports inc_hour, inc_min, sec_zero, inc_ahour, inc_amin, sw_clear, output, 1 bit each: one-clk command pulses.
REQ-012 SHALL have ports sw_run, alarm_on, edit_active, output, 1 bit each: levels.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer; the debounced level SHALL change only after the synchronized input differs from it for DEB_MS consecutive tick_1khz pulses.
REQ-014 SHALL produce a press event: one clk, on the debounced level's rising edge.
REQ-015 SHALL encode states: NORMAL=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, STOPWATCH=4, ALM_MIN=5, ALM_HOUR=6; codes 7 map to NORMAL on the next clk.
REQ-016 SHALL advance state on a mode press: n -> n+1, with wrap ALM_HOUR -> NORMAL.
REQ-017 SHALL map inc presses per state: NORMAL toggles alarm_on; SET_HOUR pulses inc_hour; SET_MIN pulses inc_min; SET_SEC pulses sec_zero; STOPWATCH toggles sw_run; ALM_MIN pulses inc_amin; ALM_HOUR pulses inc_ahour.
REQ-018 SHALL, on a zero press in STOPWATCH, pulse sw_clear and force sw_run=0; zero presses in other states SHALL have no effect.
REQ-019 SHALL register command pulses: one clk, asserted the cycle after the press event.
REQ-020 SHALL, on a same-cycle mode press and inc or zero press, act on mode only and discard the others.
REQ-021 SHALL, on same-cycle zero and inc presses in STOPWATCH, act on zero only.
REQ-022 SHALL drive edit_active=1 exactly in states 1, 2, 3, 5 and 6.
REQ-023 SHALL count tick_1hz while edit_active; any press event or state change clears the count; count reaching TIMEOUT_S SHALL force NORMAL on the next clk.
REQ-024 SHALL keep sw_run unchanged when leaving STOPWATCH.
REQ-025 SHALL keep alarm_on unchanged by mode changes and timeout.

Reset
REQ-026 SHALL, on clr=1 at a clk edge: state=NORMAL, all pulses 0, sw_run=0, alarm_on=0, synchronizers, debounced levels, timeout and repeat counters 0.
REQ-027 SHALL take reset priority over all events; a button held through reset SHALL yield one press DEB_MS ms after clr deasserts.

Configuration
REQ-028 SHALL, with AUTO_REPEAT_EN defined, in SET_HOUR, SET_MIN, ALM_MIN and ALM_HOUR, emit a further command pulse after the inc debounced level has been high for REP_DELAY_MS ms, then one every REP_RATE_MS ms while held; each repeat pulse SHALL clear the timeout count.
REQ-029 SHALL, with AUTO_REPEAT_EN undefined, emit exactly one command pulse per inc press; no repeat counter SHALL be synthesized.

Structure
REQ-030 SHALL take the state encodings, the 3-bit state width and the timing parameter defaults from shared package clock_pkg.
REQ-031 SHALL implement the synchronizer and debounce in sub-module btn_debounce, instantiated three times.

Verification
REQ-032 SHALL verify: reset, then 7 mode presses -> state sequence 1,2,3,4,5,6,0.
REQ-033 SHALL verify: btn_inc bouncing 5 times within 3 ms, then stable 25 ms, in SET_MIN (DEB_MS=20) -> exactly one inc_min pulse.
REQ-034 SHALL verify: SET_HOUR with no presses for 30 tick_1hz -> state=0 on the next clk; with a press at tick 29 -> still state 1 at tick 30.
REQ-035 SHALL verify: STOPWATCH, inc press -> sw_run=1; same-cycle zero and inc presses -> sw_clear pulse, sw_run=0.
REQ-036 SHALL verify: AUTO_REPEAT_EN defined, inc held 1000 ms in ALM_MIN -> 6 inc_amin pulses (press, 500, 600 ... 900 ms); undefined -> 1 pulse.
REQ-037 SHALL verify: clr asserted in SET_SEC mid-debounce -> all outputs at reset values on the next clk, no stale press emitted.
